vga_pixel_gen: RTL

- Pixel-generation stage directly downstream of vga_sync.
- Consumes its HorizontalCounter/VerticalCounter/HorizontalSync/VerticalSync and produces 5-6-5 RGB test-pattern video.
- Runs on Clock50, advancing once per pixel strobe.
- Pipelines colour computation and delays the syncs by the same amount, so that colour and sync leave the block aligned for the DAC pins.

---
 rtl/vga_pixel_gen_if.sv | 34 +++
 rtl/vga_pixel_gen.sv | 113 +++++++++++
 2 files changed

// File: rtl/vga_pixel_gen_if.sv
// Pixel-generator bus: vga_sync counters/syncs and pattern controls in,
// 5-6-5 RGB, delayed syncs, DataEnable and FrameCount out.
interface vga_pixel_gen_if;
  logic        PixelEnable;
  logic [9:0]  HorizontalCounter;
  logic [9:0]  VerticalCounter;
  logic        HorizontalSyncIn;
  logic        VerticalSyncIn;
  logic [1:0]  PatternSelect;
  logic [15:0] SolidColor;
  logic [4:0]  Red;
  logic [5:0]  Green;
  logic [4:0]  Blue;
  logic        HorizontalSync;
  logic        VerticalSync;
  logic        DataEnable;
  logic [7:0]  FrameCount;

  modport master (
    output PixelEnable, HorizontalCounter, VerticalCounter,
    output HorizontalSyncIn, VerticalSyncIn,
    output PatternSelect, SolidColor,
    input  Red, Green, Blue, HorizontalSync, VerticalSync,
    input  DataEnable, FrameCount
  );

  modport slave (
    input  PixelEnable, HorizontalCounter, VerticalCounter,
    input  HorizontalSyncIn, VerticalSyncIn,
    input  PatternSelect, SolidColor,
    output Red, Green, Blue, HorizontalSync, VerticalSync,
    output DataEnable, FrameCount
  );
endinterface

// File: rtl/vga_pixel_gen.sv
// Two-strobe pipelined 5-6-5 test-pattern generator behind vga_sync.
// Ports: Clock50, Reset (async, low), bus (vga_pixel_gen_if.slave).
// Option: define VGA_PIXEL_BORDER_EN for a white 1-pixel frame border.
module vga_pixel_gen #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int BAR_WIDTH = 80
) (
  input logic            Clock50,
  input logic            Reset,
  vga_pixel_gen_if.slave bus
);
  localparam logic [9:0] HV = 10'(H_VISIBLE);
  localparam logic [9:0] VV = 10'(V_VISIBLE);
  localparam logic [15:0] WHITE = 16'hFFFF;

  logic [9:0]  h1;
  logic [9:0]  v1;
  logic [9:0]  v1_prev;
  logic        vis1;
  logic        hs1;
  logic        vs1;
  logic [1:0]  mode;
  logic [7:0]  frame;
  logic [3:0]  bar;
  logic [15:0] rgb;
  logic        frame_edge;

  // Entering vblank: first strobe where stage-1 line reaches V_VISIBLE.
  assign frame_edge = (v1 == VV) && (v1_prev != VV);
  assign bus.FrameCount = frame;

  // Compare chain instead of a divider; the lowest matching bound wins.
  always_comb begin
    bar = 4'd8;
    for (int i = 8; i >= 1; i--) begin
      if ({22'd0, h1} < 32'(i * BAR_WIDTH))
        bar = 4'(i - 1);
    end
  end

  always_comb begin
    rgb = '0;
    if (vis1) begin
      case (mode)
        2'd0: begin
          case (bar)
            4'd0:    rgb = WHITE;
            4'd1:    rgb = 16'hFFE0;
            4'd2:    rgb = 16'h07FF;
            4'd3:    rgb = 16'h07E0;
            4'd4:    rgb = 16'hF81F;
            4'd5:    rgb = 16'hF800;
            4'd6:    rgb = 16'h001F;
            default: rgb = '0;
          endcase
        end
        2'd1: begin
          if (h1[5] ^ v1[5])
            rgb = WHITE;
        end
        2'd2: begin
          rgb = {5'(h1[8:4] + frame[4:0]),
                 v1[8:3],
                 frame[5:1]};
        end
        default: rgb = bus.SolidColor;
      endcase
`ifdef VGA_PIXEL_BORDER_EN
      if (h1 == 10'd0 || h1 == HV - 10'd1 ||
          v1 == 10'd0 || v1 == VV - 10'd1)
        rgb = WHITE;
`endif
    end
  end

  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      h1                 <= '0;
      v1                 <= '0;
      v1_prev            <= '0;
      vis1               <= 1'b0;
      hs1                <= 1'b1;
      vs1                <= 1'b1;
      mode               <= '0;
      frame              <= '0;
      bus.Red            <= '0;
      bus.Green          <= '0;
      bus.Blue           <= '0;
      bus.DataEnable     <= 1'b0;
      bus.HorizontalSync <= 1'b1;
      bus.VerticalSync   <= 1'b1;
    end else if (bus.PixelEnable) begin
      h1      <= bus.HorizontalCounter;
      v1      <= bus.VerticalCounter;
      v1_prev <= v1;
      vis1    <= (bus.HorizontalCounter < HV) &&
                 (bus.VerticalCounter < VV);
      hs1     <= bus.HorizontalSyncIn;
      vs1     <= bus.VerticalSyncIn;
      if (frame_edge) begin
        frame <= frame + 8'd1;
        mode  <= bus.PatternSelect;
      end
      bus.Red            <= rgb[15:11];
      bus.Green          <= rgb[10:5];
      bus.Blue           <= rgb[4:0];
      bus.DataEnable     <= vis1;
      bus.HorizontalSync <= hs1;
      bus.VerticalSync   <= vs1;
    end
  end
endmodule
